// File: rtl/arena_pkg.sv
// Shared types and constants for the arena access controller: cell and bomb codes,
// command encodings, controller states and the starting-layout generator.
package arena_pkg;

  localparam int ARENA_W = 10;
  localparam int CELLS   = 100;
  localparam int ADDR_W  = 7;

  localparam logic [ADDR_W-1:0] START_A   = 7'd11;
  localparam logic [ADDR_W-1:0] START_B   = 7'd88;
  localparam logic [ADDR_W-1:0] LAST_CELL = 7'd99;
  localparam logic [ADDR_W-1:0] ROW_STEP  = 7'd10;
  localparam logic [ADDR_W-1:0] COL_STEP  = 7'd1;

  localparam logic [1:0] CELL_BLANK    = 2'b00;
  localparam logic [1:0] CELL_BLOCK    = 2'b01;
  localparam logic [1:0] CELL_PLAYER_A = 2'b10;
  localparam logic [1:0] CELL_PLAYER_B = 2'b11;

  localparam logic [1:0] BOMB_A = 2'b01;
  localparam logic [1:0] BOMB_B = 2'b10;

  localparam logic [2:0] CMD_UP    = 3'd0;
  localparam logic [2:0] CMD_DOWN  = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_BOMB  = 3'd4;

  typedef enum logic [2:0] {
    INIT, IDLE, RD, CHK, WR_DST, WR_SRC, BOMB, ACK
  } state_t;

  localparam int NUM_BLOCKS = 14;
  localparam logic [ADDR_W-1:0] BLOCK_CELLS [0:NUM_BLOCKS-1] = '{
    7'd13, 7'd17, 7'd24, 7'd32, 7'd34, 7'd38, 7'd46,
    7'd51, 7'd56, 7'd57, 7'd62, 7'd63, 7'd76, 7'd84
  };

  // Starting code of one cell; player starts override everything else.
  function automatic logic [1:0] init_code(input logic [ADDR_W-1:0] addr);
    logic [1:0] code;
    int row;
    int col;
    row  = int'(addr) / ARENA_W;
    col  = int'(addr) % ARENA_W;
    code = CELL_BLANK;
    if (row == 0 || row == ARENA_W - 1 || col == 0 || col == ARENA_W - 1) begin
      code = CELL_BLOCK;
    end else begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (addr == BLOCK_CELLS[i]) begin
          code = CELL_BLOCK;
        end else begin
          code = code;
        end
      end
    end
    if (addr == START_A) begin
      code = CELL_PLAYER_A;
    end else if (addr == START_B) begin
      code = CELL_PLAYER_B;
    end else begin
      code = code;
    end
    return code;
  endfunction

endpackage

// File: rtl/arena_access_ctrl_if.sv
// Player command handshakes plus arena/bomb RAM ports of the arena access controller.
interface arena_access_ctrl_if;
  import arena_pkg::*;

  logic              req_a;
  logic [2:0]        cmd_a;
  logic              ack_a;
  logic              ok_a;
  logic              req_b;
  logic [2:0]        cmd_b;
  logic              ack_b;
  logic              ok_b;
  logic [ADDR_W-1:0] ar_addr;
  logic              ar_we;
  logic [1:0]        ar_wdata;
  logic [1:0]        ar_rdata;
  logic              bomb_we;
  logic [ADDR_W-1:0] bomb_addr;
  logic [1:0]        bomb_wdata;
  logic [ADDR_W-1:0] pos_a;
  logic [ADDR_W-1:0] pos_b;
  logic              init_done;
  logic              busy;

  modport slave (
    input  req_a, cmd_a, req_b, cmd_b, ar_rdata,
    output ack_a, ok_a, ack_b, ok_b, ar_addr, ar_we, ar_wdata,
           bomb_we, bomb_addr, bomb_wdata, pos_a, pos_b, init_done, busy
  );

  modport master (
    output req_a, cmd_a, req_b, cmd_b, ar_rdata,
    input  ack_a, ok_a, ack_b, ok_b, ar_addr, ar_we, ar_wdata,
           bomb_we, bomb_addr, bomb_wdata, pos_a, pos_b, init_done, busy
  );

endinterface

// File: rtl/arena_access_ctrl_arb.sv
// Two-way round-robin arbiter: on contention the requester not served last wins.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic prio_b_r;

  // Grant decode, only while the controller can accept a command
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && (!req_b || !prio_b_r)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end else begin
        gnt_a = 1'b0;
      end
    end else begin
      gnt_b = 1'b0;
    end
  end

  // Last-grant pointer: favour the other player after each grant
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b_r <= 1'b0;
    end else if (gnt_a) begin
      prio_b_r <= 1'b1;
    end else if (gnt_b) begin
      prio_b_r <= 1'b0;
    end else begin
      prio_b_r <= prio_b_r;
    end
  end

endmodule

// File: rtl/arena_access_ctrl.sv
// Arena RAM owner: sweeps the starting layout, then serialises player move/bomb
// commands as read-check-write sequences on the single-port cell RAM.
module arena_access_ctrl
  import arena_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  arena_access_ctrl_if.slave bus
);

  state_t            state_r, state_nx_s;
  logic [ADDR_W-1:0] cnt_r, cnt_nx_s;
  logic [ADDR_W-1:0] pos_a_r, pos_a_nx_s;
  logic [ADDR_W-1:0] pos_b_r, pos_b_nx_s;
  logic              player_r, player_nx_s;
  logic [2:0]        cmd_r, cmd_nx_s;
  logic              ok_r, ok_nx_s;
  logic              init_done_r, init_done_nx_s;

  logic              arb_en_s, gnt_a_s, gnt_b_s;
  logic [2:0]        gcmd_s;
  logic [ADDR_W-1:0] own_pos_s, tgt_s;
  logic [1:0]        own_code_s;

  assign arb_en_s = (state_r == IDLE);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en_s),
    .req_a (bus.req_a),
    .req_b (bus.req_b),
    .gnt_a (gnt_a_s),
    .gnt_b (gnt_b_s)
  );

  // Position and target of the granted player; walls keep targets inside the arena
  always_comb begin
    own_pos_s  = player_r ? pos_b_r : pos_a_r;
    own_code_s = player_r ? CELL_PLAYER_B : CELL_PLAYER_A;
    gcmd_s     = gnt_b_s ? bus.cmd_b : bus.cmd_a;
    case (cmd_r)
      CMD_UP:    tgt_s = own_pos_s - ROW_STEP;
      CMD_DOWN:  tgt_s = own_pos_s + ROW_STEP;
      CMD_LEFT:  tgt_s = own_pos_s - COL_STEP;
      CMD_RIGHT: tgt_s = own_pos_s + COL_STEP;
      default:   tgt_s = own_pos_s;
    endcase
  end

  // Next-state logic for the sweep, arbitration and command sequencing
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    pos_a_nx_s     = pos_a_r;
    pos_b_nx_s     = pos_b_r;
    player_nx_s    = player_r;
    cmd_nx_s       = cmd_r;
    ok_nx_s        = ok_r;
    init_done_nx_s = init_done_r;
    case (state_r)
      INIT: begin
        if (cnt_r == LAST_CELL) begin
          state_nx_s     = IDLE;
          cnt_nx_s       = 7'd0;
          init_done_nx_s = 1'b1;
        end else begin
          cnt_nx_s = cnt_r + 7'd1;
        end
      end
      IDLE: begin
        if (gnt_a_s || gnt_b_s) begin
          player_nx_s = gnt_b_s;
          cmd_nx_s    = gcmd_s;
          case (gcmd_s)
            CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT: state_nx_s = RD;
            CMD_BOMB: state_nx_s = BOMB;
            default: begin
              state_nx_s = ACK;
              ok_nx_s    = 1'b0;
            end
          endcase
        end else begin
          state_nx_s = IDLE;
        end
      end
      RD: state_nx_s = CHK;
      CHK: begin
        if (bus.ar_rdata == CELL_BLANK) begin
          state_nx_s = WR_DST;
        end else begin
          state_nx_s = ACK;
          ok_nx_s    = 1'b0;
        end
      end
      WR_DST: state_nx_s = WR_SRC;
      WR_SRC: begin
        state_nx_s = ACK;
        ok_nx_s    = 1'b1;
        if (player_r) begin
          pos_b_nx_s = tgt_s;
        end else begin
          pos_a_nx_s = tgt_s;
        end
      end
      BOMB: begin
        state_nx_s = ACK;
        ok_nx_s    = 1'b1;
      end
      ACK: state_nx_s = IDLE;
      default: state_nx_s = INIT;
    endcase
  end

  // State registers; reset aborts any command in flight and restarts the sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= INIT;
      cnt_r       <= 7'd0;
      pos_a_r     <= START_A;
      pos_b_r     <= START_B;
      player_r    <= 1'b0;
      cmd_r       <= 3'd0;
      ok_r        <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      pos_a_r     <= pos_a_nx_s;
      pos_b_r     <= pos_b_nx_s;
      player_r    <= player_nx_s;
      cmd_r       <= cmd_nx_s;
      ok_r        <= ok_nx_s;
      init_done_r <= init_done_nx_s;
    end
  end

  // Port decode from registered state; write enables are suppressed while rst is high
  always_comb begin
    bus.ar_we      = 1'b0;
    bus.ar_addr    = tgt_s;
    bus.ar_wdata   = CELL_BLANK;
    bus.bomb_we    = 1'b0;
    bus.bomb_addr  = own_pos_s;
    bus.bomb_wdata = player_r ? BOMB_B : BOMB_A;
    case (state_r)
      INIT: begin
        bus.ar_we    = ~rst;
        bus.ar_addr  = cnt_r;
        bus.ar_wdata = init_code(cnt_r);
      end
      WR_DST: begin
        bus.ar_we    = ~rst;
        bus.ar_wdata = own_code_s;
      end
      WR_SRC: begin
        bus.ar_we   = ~rst;
        bus.ar_addr = own_pos_s;
      end
      BOMB: bus.bomb_we = ~rst;
      default: bus.ar_we = 1'b0;
    endcase
    bus.ack_a     = (state_r == ACK) && !player_r;
    bus.ack_b     = (state_r == ACK) && player_r;
    bus.ok_a      = bus.ack_a && ok_r;
    bus.ok_b      = bus.ack_b && ok_r;
    bus.pos_a     = pos_a_r;
    bus.pos_b     = pos_b_r;
    bus.init_done = init_done_r;
    bus.busy      = (state_r != IDLE);
  end

endmodule

// File: tb/tb_arena_access_ctrl.sv
// Directed bench for arena_access_ctrl with arena and bomb RAM models.
module tb_arena_access_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  int          ar_wr_cnt;
  int          bomb_cnt;
  int          ack_a_cnt;
  int          ack_b_cnt;
  logic [6:0]  last_baddr;
  logic [1:0]  last_bdata;
  logic [1:0]  mem [0:127];

  arena_access_ctrl_if bus ();

  arena_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arena RAM model: synchronous read; scrubbed to a junk code while in reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 2'b11;
    end else if (bus.ar_we) begin
      mem[bus.ar_addr] <= bus.ar_wdata;
    end
    bus.ar_rdata <= mem[bus.ar_addr];
  end

  // Event counters for writes and acks
  always @(posedge clk) begin
    if (bus.ar_we) ar_wr_cnt <= ar_wr_cnt + 1;
    if (bus.bomb_we) begin
      bomb_cnt   <= bomb_cnt + 1;
      last_baddr <= bus.bomb_addr;
      last_bdata <= bus.bomb_wdata;
    end
    if (bus.ack_a) ack_a_cnt <= ack_a_cnt + 1;
    if (bus.ack_b) ack_b_cnt <= ack_b_cnt + 1;
  end

  function automatic logic [1:0] exp_cell(input int a);
    int r;
    int c;
    r = a / 10;
    c = a % 10;
    if (r == 0 || r == 9 || c == 0 || c == 9) return 2'b01;
    case (a)
      13, 17, 24, 32, 34, 38, 46, 51, 56, 57, 62, 63, 76, 84: return 2'b01;
      11: return 2'b10;
      88: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic count_layout_errors(output int errs);
    errs = 0;
    for (int i = 0; i < 100; i++) if (mem[i] !== exp_cell(i)) errs++;
  endtask

  // Issue one command from the IDLE cycle, drop req after grant, time the ack
  task automatic issue_cmd(input bit pl, input logic [2:0] c, output int lat, output bit okv);
    lat = 99;
    okv = 1'b0;
    @(negedge clk);
    if (pl) begin bus.req_b = 1'b1; bus.cmd_b = c; end
    else    begin bus.req_a = 1'b1; bus.cmd_a = c; end
    @(posedge clk);
    #1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (pl ? bus.ack_b : bus.ack_a) begin
        lat = k;
        okv = pl ? bus.ok_b : bus.ok_a;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int w0;
    int errs;
    @(negedge clk);
    total++; if (bus.ar_we !== 1'b0 || bus.bomb_we !== 1'b0) begin bad++; $display("FAIL reset_we: ar_we=%0b bomb_we=%0b want 0 0", bus.ar_we, bus.bomb_we); end
    total++; if ({bus.ack_a, bus.ok_a, bus.ack_b, bus.ok_b, bus.init_done} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {bus.ack_a, bus.ok_a, bus.ack_b, bus.ok_b, bus.init_done}); end
    total++; if (bus.pos_a !== 7'd11 || bus.pos_b !== 7'd88) begin bad++; $display("FAIL reset_pos: got %0d %0d want 11 88", bus.pos_a, bus.pos_b); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %0b want 1", bus.busy); end
    rst = 1'b0;
    w0  = ar_wr_cnt;
    #1;
    total++; if (bus.ar_we !== 1'b1 || bus.ar_addr !== 7'd0) begin bad++; $display("FAIL init_first: we=%0b addr=%0d want 1 0", bus.ar_we, bus.ar_addr); end
    repeat (99) @(negedge clk);
    total++; if (bus.ar_addr !== 7'd99 || bus.init_done !== 1'b0) begin bad++; $display("FAIL init_last: addr=%0d done=%0b want 99 0", bus.ar_addr, bus.init_done); end
    @(negedge clk);
    total++; if (bus.init_done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL init_done: done=%0b busy=%0b want 1 0", bus.init_done, bus.busy); end
    total++; if (ar_wr_cnt - w0 !== 100) begin bad++; $display("FAIL init_writes: got %0d want 100", ar_wr_cnt - w0); end
    count_layout_errors(errs);
    total++; if (errs !== 0) begin bad++; $display("FAIL init_layout: bad cells=%0d want 0", errs); end
  endtask

  task automatic test_move_ok;
    int lat; bit okv; int w0;
    w0 = ar_wr_cnt;
    issue_cmd(1'b0, 3'd3, lat, okv);
    total++; if (lat !== 5 || okv !== 1'b1) begin bad++; $display("FAIL move_ok_ack: lat=%0d ok=%0b want 5 1", lat, okv); end
    total++; if (bus.pos_a !== 7'd12) begin bad++; $display("FAIL move_ok_pos: got %0d want 12", bus.pos_a); end
    total++; if (mem[12] !== 2'b10 || mem[11] !== 2'b00) begin bad++; $display("FAIL move_ok_cells: c12=%b c11=%b want 10 00", mem[12], mem[11]); end
    total++; if (ar_wr_cnt - w0 !== 2) begin bad++; $display("FAIL move_ok_writes: got %0d want 2", ar_wr_cnt - w0); end
  endtask

  task automatic test_move_blocked;
    int lat; bit okv; int w0;
    w0 = ar_wr_cnt;
    issue_cmd(1'b0, 3'd3, lat, okv);
    total++; if (lat !== 3 || okv !== 1'b0) begin bad++; $display("FAIL blocked_ack: lat=%0d ok=%0b want 3 0", lat, okv); end
    total++; if (bus.pos_a !== 7'd12 || ar_wr_cnt - w0 !== 0) begin bad++; $display("FAIL blocked_state: pos=%0d writes=%0d want 12 0", bus.pos_a, ar_wr_cnt - w0); end
    total++; if (mem[13] !== 2'b01) begin bad++; $display("FAIL blocked_cell: c13=%b want 01", mem[13]); end
  endtask

  task automatic test_bomb_illegal;
    int lat; bit okv; int w0; int b0;
    w0 = ar_wr_cnt; b0 = bomb_cnt;
    issue_cmd(1'b1, 3'd4, lat, okv);
    total++; if (lat !== 2 || okv !== 1'b1) begin bad++; $display("FAIL bomb_ack: lat=%0d ok=%0b want 2 1", lat, okv); end
    total++; if (bomb_cnt - b0 !== 1 || last_baddr !== 7'd88 || last_bdata !== 2'b10) begin bad++; $display("FAIL bomb_write: n=%0d addr=%0d data=%b want 1 88 10", bomb_cnt - b0, last_baddr, last_bdata); end
    total++; if (ar_wr_cnt - w0 !== 0) begin bad++; $display("FAIL bomb_arena: writes=%0d want 0", ar_wr_cnt - w0); end
    w0 = ar_wr_cnt; b0 = bomb_cnt;
    issue_cmd(1'b1, 3'd7, lat, okv);
    total++; if (lat !== 1 || okv !== 1'b0) begin bad++; $display("FAIL illegal_ack: lat=%0d ok=%0b want 1 0", lat, okv); end
    total++; if (ar_wr_cnt - w0 !== 0 || bomb_cnt - b0 !== 0) begin bad++; $display("FAIL illegal_writes: ar=%0d bomb=%0d want 0 0", ar_wr_cnt - w0, bomb_cnt - b0); end
    total++; if (bus.pos_b !== 7'd88) begin bad++; $display("FAIL illegal_pos: got %0d want 88", bus.pos_b); end
  endtask

  // A up (wall) and B down (wall) both blocked: acks every 4 cycles, alternating
  task automatic test_back_to_back;
    int  when [0:3];
    bit  who  [0:3];
    bit  okr  [0:3];
    int  n;
    n = 0;
    for (int i = 0; i < 4; i++) begin when[i] = -1; who[i] = 1'b0; okr[i] = 1'b1; end
    @(negedge clk);
    bus.req_a = 1'b1; bus.cmd_a = 3'd0;
    bus.req_b = 1'b1; bus.cmd_b = 3'd1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.ack_a || bus.ack_b) begin
        when[n] = k;
        who[n]  = bus.ack_b;
        okr[n]  = bus.ok_a | bus.ok_b;
        n++;
        if (n == 4) begin
          bus.req_a = 1'b0;
          bus.req_b = 1'b0;
          break;
        end
      end
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    total++; if (who[0] !== 1'b0 || who[1] !== 1'b1 || who[2] !== 1'b0 || who[3] !== 1'b1) begin bad++; $display("FAIL b2b_order: got %0b%0b%0b%0b want 0101 (0=A)", who[0], who[1], who[2], who[3]); end
    total++; if (when[0] !== 3 || when[1] !== 7 || when[2] !== 11 || when[3] !== 15) begin bad++; $display("FAIL b2b_timing: got %0d %0d %0d %0d want 3 7 11 15", when[0], when[1], when[2], when[3]); end
    total++; if (okr[0] | okr[1] | okr[2] | okr[3]) begin bad++; $display("FAIL b2b_ok: some ok set, want all 0"); end
    total++; if (bus.pos_a !== 7'd12 || bus.pos_b !== 7'd88) begin bad++; $display("FAIL b2b_pos: got %0d %0d want 12 88", bus.pos_a, bus.pos_b); end
  endtask

  task automatic test_reset_abort;
    int a0; int w0; int errs;
    a0 = ack_a_cnt;
    @(negedge clk);
    bus.req_a = 1'b1; bus.cmd_a = 3'd1;
    @(posedge clk);
    #1;
    bus.req_a = 1'b0;
    @(negedge clk);
    total++; if (bus.ar_we !== 1'b0 || bus.ar_addr !== 7'd22) begin bad++; $display("FAIL abort_rd: we=%0b addr=%0d want 0 22", bus.ar_we, bus.ar_addr); end
    repeat (2) @(negedge clk);
    total++; if (bus.ar_we !== 1'b1 || bus.ar_addr !== 7'd22 || bus.ar_wdata !== 2'b10) begin bad++; $display("FAIL abort_wrdst: we=%0b addr=%0d data=%b want 1 22 10", bus.ar_we, bus.ar_addr, bus.ar_wdata); end
    rst = 1'b1;
    #1;
    total++; if (bus.ar_we !== 1'b0) begin bad++; $display("FAIL abort_we_gated: got %0b want 0", bus.ar_we); end
    @(negedge clk);
    total++; if (bus.pos_a !== 7'd11 || bus.init_done !== 1'b0) begin bad++; $display("FAIL abort_regs: pos=%0d done=%0b want 11 0", bus.pos_a, bus.init_done); end
    @(negedge clk);
    rst = 1'b0;
    w0  = ar_wr_cnt;
    #1;
    total++; if (bus.ar_we !== 1'b1 || bus.ar_addr !== 7'd0) begin bad++; $display("FAIL abort_restart: we=%0b addr=%0d want 1 0", bus.ar_we, bus.ar_addr); end
    repeat (100) @(negedge clk);
    total++; if (bus.init_done !== 1'b1 || ar_wr_cnt - w0 !== 100) begin bad++; $display("FAIL abort_sweep: done=%0b writes=%0d want 1 100", bus.init_done, ar_wr_cnt - w0); end
    total++; if (ack_a_cnt !== a0) begin bad++; $display("FAIL abort_noack: acks=%0d want 0", ack_a_cnt - a0); end
    count_layout_errors(errs);
    total++; if (errs !== 0) begin bad++; $display("FAIL abort_layout: bad cells=%0d want 0", errs); end
  endtask

  initial begin
    total = 0; bad = 0;
    ar_wr_cnt = 0; bomb_cnt = 0; ack_a_cnt = 0; ack_b_cnt = 0;
    last_baddr = 7'd0; last_bdata = 2'b00;
    rst = 1'b1;
    bus.req_a = 1'b0; bus.cmd_a = 3'd0;
    bus.req_b = 1'b0; bus.cmd_b = 3'd0;
    repeat (3) @(posedge clk);
    test_reset;
    test_move_ok;
    test_move_blocked;
    test_bomb_illegal;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
